// File: rtl/pipeline_trace_tracker.sv
// rtl/pipeline_trace_tracker.sv - producer side of the pipeline trace interface
//
// Purpose: tags every fetched instruction, shadows tag+valid through the
// F/D/E/M/W stages under stall/flush, stamps the cycle each instruction
// entered each stage, and queues a retire record per writeback into a
// FIFO drained by a valid/ready consumer.
//
// Optional feature macro: TRACE_STALL_CNT_EN (per-instruction F/D stall
// counters reported on ret_stalls; tied to 0 when undefined).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    F and D hold, bubble into E
//   flush_if / flush_id      kill instruction in F / D
//   ret_valid / ret_ready    retire record handshake
//   ret_tag                  tag of retired instruction
//   ret_cyc_f .. ret_cyc_w   cycle the instruction entered each stage
//   ret_stalls               F/D stall cycles of the retired instruction
//   overflow                 sticky: a retire record was dropped
//   retired_cnt              records accepted into the FIFO since reset

module pipeline_trace_tracker #(
  parameter int TAG_W      = 8,
  parameter int CYC_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush_if,
  input  logic             flush_id,
  output logic             ret_valid,
  input  logic             ret_ready,
  output logic [TAG_W-1:0] ret_tag,
  output logic [CYC_W-1:0] ret_cyc_f,
  output logic [CYC_W-1:0] ret_cyc_d,
  output logic [CYC_W-1:0] ret_cyc_e,
  output logic [CYC_W-1:0] ret_cyc_m,
  output logic [CYC_W-1:0] ret_cyc_w,
  output logic [7:0]       ret_stalls,
  output logic             overflow,
  output logic [31:0]      retired_cnt
);

  localparam int REC_W = TAG_W + 5 * CYC_W + 8;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CYC_W-1:0] cyc_q, cyc_n;
  logic [TAG_W-1:0] tag_q;

  // F always holds a live instruction: there is no fetch-side bubble source.
  logic [TAG_W-1:0] f_tag_q;
  logic [CYC_W-1:0] f_cf_q;
  logic             d_v_q;
  logic [TAG_W-1:0] d_tag_q;
  logic [CYC_W-1:0] d_cf_q, d_cd_q;
  logic             e_v_q;
  logic [TAG_W-1:0] e_tag_q;
  logic [CYC_W-1:0] e_cf_q, e_cd_q, e_ce_q;
  logic [7:0]       e_stl_q;
  logic             m_v_q;
  logic [TAG_W-1:0] m_tag_q;
  logic [CYC_W-1:0] m_cf_q, m_cd_q, m_ce_q, m_cm_q;
  logic [7:0]       m_stl_q;
  logic             w_v_q;
  logic [TAG_W-1:0] w_tag_q;
  logic [CYC_W-1:0] w_cf_q, w_cd_q, w_ce_q, w_cm_q, w_cw_q;
  logic [7:0]       w_stl_q;

  logic [7:0] f_stl, d_stl;
  logic       adv;

  // Any flush forces the front end to move, even under stall.
  assign adv   = !stall || flush_if || flush_id;
  assign cyc_n = cyc_q + CYC_W'(1);

`ifdef TRACE_STALL_CNT_EN
  logic [7:0] f_stl_q, d_stl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_stl_q <= '0;
      d_stl_q <= '0;
    end else if (adv) begin
      f_stl_q <= '0;
      d_stl_q <= f_stl_q;
    end else begin
      if (f_stl_q != 8'hFF) f_stl_q <= f_stl_q + 8'd1;
      if (d_stl_q != 8'hFF) d_stl_q <= d_stl_q + 8'd1;
    end
  end

  assign f_stl = f_stl_q;
  assign d_stl = d_stl_q;
`else
  assign f_stl = '0;
  assign d_stl = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      tag_q   <= TAG_W'(1);
      f_tag_q <= '0;
      f_cf_q  <= '0;
      d_v_q   <= 1'b0;
      d_tag_q <= '0;
      d_cf_q  <= '0;
      d_cd_q  <= '0;
      e_v_q   <= 1'b0;
      e_tag_q <= '0;
      e_cf_q  <= '0;
      e_cd_q  <= '0;
      e_ce_q  <= '0;
      e_stl_q <= '0;
      m_v_q   <= 1'b0;
      m_tag_q <= '0;
      m_cf_q  <= '0;
      m_cd_q  <= '0;
      m_ce_q  <= '0;
      m_cm_q  <= '0;
      m_stl_q <= '0;
      w_v_q   <= 1'b0;
      w_tag_q <= '0;
      w_cf_q  <= '0;
      w_cd_q  <= '0;
      w_ce_q  <= '0;
      w_cm_q  <= '0;
      w_cw_q  <= '0;
      w_stl_q <= '0;
    end else begin
      cyc_q <= cyc_n;
      if (adv) begin
        tag_q   <= tag_q + TAG_W'(1);
        f_tag_q <= tag_q;
        f_cf_q  <= cyc_n;
        d_v_q   <= !flush_if;
        d_tag_q <= f_tag_q;
        d_cf_q  <= f_cf_q;
        d_cd_q  <= cyc_n;
        e_v_q   <= d_v_q && !flush_id;
        e_tag_q <= d_tag_q;
        e_cf_q  <= d_cf_q;
        e_cd_q  <= d_cd_q;
        e_ce_q  <= cyc_n;
        e_stl_q <= d_stl;
      end else begin
        e_v_q <= 1'b0;
      end
      m_v_q   <= e_v_q;
      m_tag_q <= e_tag_q;
      m_cf_q  <= e_cf_q;
      m_cd_q  <= e_cd_q;
      m_ce_q  <= e_ce_q;
      m_cm_q  <= cyc_n;
      m_stl_q <= e_stl_q;
      w_v_q   <= m_v_q;
      w_tag_q <= m_tag_q;
      w_cf_q  <= m_cf_q;
      w_cd_q  <= m_cd_q;
      w_ce_q  <= m_ce_q;
      w_cm_q  <= m_cm_q;
      w_cw_q  <= cyc_n;
      w_stl_q <= m_stl_q;
    end
  end

  // Retire FIFO: shift register, so the head entry is itself the output register.
  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [REC_W-1:0] mem_d [FIFO_DEPTH];
  logic [REC_W-1:0] w_rec;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_pop;
  logic             ret_valid_q, overflow_q;
  logic [31:0]      retired_q;
  logic             pop, full, accept, drop;

  assign w_rec   = {w_tag_q, w_cf_q, w_cd_q, w_ce_q, w_cm_q, w_cw_q, w_stl_q};
  assign pop     = ret_valid_q && ret_ready;
  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign accept  = w_v_q && (!full || pop);
  assign drop    = w_v_q && full && !pop;
  assign cnt_pop = cnt_q - CNT_W'(pop);

  always_comb begin
    mem_d = mem_q;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (accept && cnt_pop == CNT_W'(i)) mem_d[i] = w_rec;
    end
    cnt_d = cnt_pop + CNT_W'(accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      cnt_q       <= '0;
      ret_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      retired_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      cnt_q       <= cnt_d;
      ret_valid_q <= (cnt_d != '0);
      if (drop) overflow_q <= 1'b1;
      if (accept) retired_q <= retired_q + 32'd1;
    end
  end

  assign {ret_tag, ret_cyc_f, ret_cyc_d, ret_cyc_e, ret_cyc_m, ret_cyc_w, ret_stalls} = mem_q[0];
  assign ret_valid   = ret_valid_q;
  assign overflow    = overflow_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_pipeline_trace_tracker.sv
// tb/tb_pipeline_trace_tracker.sv - directed scoreboard bench for pipeline_trace_tracker
module tb_pipeline_trace_tracker;

`ifdef TRACE_STALL_CNT_EN
  localparam bit STL_EN = 1'b1;
`else
  localparam bit STL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush_if, flush_id, ret_ready;
  logic        ret_valid, overflow;
  logic [7:0]  ret_tag, ret_stalls;
  logic [15:0] ret_cyc_f, ret_cyc_d, ret_cyc_e, ret_cyc_m, ret_cyc_w;
  logic [31:0] retired_cnt;

  pipeline_trace_tracker dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_if(flush_if), .flush_id(flush_id),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_tag(ret_tag),
    .ret_cyc_f(ret_cyc_f), .ret_cyc_d(ret_cyc_d), .ret_cyc_e(ret_cyc_e),
    .ret_cyc_m(ret_cyc_m), .ret_cyc_w(ret_cyc_w), .ret_stalls(ret_stalls),
    .overflow(overflow), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tag;
    logic [15:0] cf, cd, ce, cm, cw;
    int          st;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] killed_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  // Reference front end: F is always occupied, D may hold a bubble.
  logic [15:0] cyc_m;
  logic [7:0]  ntag_m, mf_tag, md_tag;
  logic [15:0] mf_cf, md_cf, md_cd;
  int          mf_st, md_st;
  logic        md_v;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic model_reset();
    cyc_m  = 16'd0;
    ntag_m = 8'd1;
    mf_tag = 8'd0;
    mf_cf  = 16'd0;
    mf_st  = 0;
    md_v   = 1'b0;
    md_tag = 8'd0;
    md_cf  = 16'd0;
    md_cd  = 16'd0;
    md_st  = 0;
    exp_q.delete();
    killed_q.delete();
  endtask

  task automatic model_cycle(input logic s, input logic fi, input logic fd);
    rec_t r;
    if (!s || fi || fd) begin
      if (md_v && !fd) begin
        r.tag = md_tag; r.cf = md_cf; r.cd = md_cd;
        r.ce = cyc_m + 16'd1; r.cm = cyc_m + 16'd2; r.cw = cyc_m + 16'd3;
        r.st = md_st;
        exp_q.push_back(r);
      end
      if (md_v && fd) killed_q.push_back(md_tag);
      if (fi) killed_q.push_back(mf_tag);
      md_v   = !fi;
      md_tag = mf_tag;
      md_cf  = mf_cf;
      md_cd  = cyc_m + 16'd1;
      md_st  = mf_st;
      mf_tag = ntag_m;
      mf_cf  = cyc_m + 16'd1;
      mf_st  = 0;
      ntag_m = ntag_m + 8'd1;
    end else begin
      if (mf_st < 255) mf_st++;
      if (md_st < 255) md_st++;
    end
    cyc_m = cyc_m + 16'd1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; stall = 1'b0; flush_if = 1'b0; flush_id = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at a negedge: check any record popped at the coming edge, then advance.
  task automatic step(input logic s, input logic fi, input logic fd);
    rec_t e;
    int   hit;
    stall = s; flush_if = fi; flush_id = fd;
    if (ret_valid === 1'b1 && ret_ready) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_empty observed tag=%0h expected no record", ret_tag);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_tag",   32'(ret_tag),   32'(e.tag));
        chk("sb_cyc_f", 32'(ret_cyc_f), 32'(e.cf));
        chk("sb_cyc_d", 32'(ret_cyc_d), 32'(e.cd));
        chk("sb_cyc_e", 32'(ret_cyc_e), 32'(e.ce));
        chk("sb_cyc_m", 32'(ret_cyc_m), 32'(e.cm));
        chk("sb_cyc_w", 32'(ret_cyc_w), 32'(e.cw));
        chk("sb_stalls", 32'(ret_stalls), STL_EN ? 32'(e.st) : 32'd0);
      end
      hit = 0;
      foreach (killed_q[i]) if (killed_q[i] == ret_tag) hit = 1;
      chk("killed_tag_retired", 32'(hit), 32'd0);
    end
    model_cycle(s, fi, fd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic first_retire_checks(input int c);
    if (c < 5) chk("early_valid", 32'(ret_valid), 32'd0);
    if (c == 5) begin
      chk("first_valid", 32'(ret_valid), 32'd1);
      chk("first_tag",   32'(ret_tag),   32'd0);
    end
  endtask

  logic [15:0] gap;

  initial begin
    rst = 1'b1; stall = 1'b0; flush_if = 1'b0; flush_id = 1'b0; ret_ready = 1'b1;
    do_reset(2);
    chk("rst_valid",    32'(ret_valid), 32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    chk("rst_retired",  retired_cnt,    32'd0);
    chk("rst_tag",      32'(ret_tag),   32'd0);

    // Stall at 3-4, stall+flush_if+flush_id at 6, consumer stops at 17.
    for (int c = 0; c < 20; c++) begin
      ret_ready = (c < 17);
      first_retire_checks(c);
      if (c == 9) begin
        gap = ret_cyc_e - ret_cyc_d;
        chk("stall_tag",    32'(ret_tag),    32'd2);
        chk("stall_gap_de", 32'(gap),        32'd3);
        chk("stall_count",  32'(ret_stalls), STL_EN ? 32'd2 : 32'd0);
      end
      step(c == 3 || c == 4 || c == 6, c == 6, c == 6);
    end
    chk("pre_rst_retired",  retired_cnt,    32'd12);
    chk("pre_rst_overflow", 32'(overflow),  32'd0);
    chk("pre_rst_valid",    32'(ret_valid), 32'd1);

    // Reset mid-operation with records queued.
    do_reset(1);
    chk("midrst_valid",    32'(ret_valid), 32'd0);
    chk("midrst_retired",  retired_cnt,    32'd0);
    chk("midrst_overflow", 32'(overflow),  32'd0);
    ret_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      first_retire_checks(c);
      step(1'b0, 1'b0, 1'b0);
    end

    // Consumer blocked: four records held, fifth dropped.
    do_reset(1);
    ret_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c >= 5) begin
        chk("hold_valid", 32'(ret_valid), 32'd1);
        chk("hold_tag",   32'(ret_tag),   32'd0);
        chk("hold_cyc_f", 32'(ret_cyc_f), 32'd0);
        chk("hold_cyc_d", 32'(ret_cyc_d), 32'd1);
        chk("hold_cyc_w", 32'(ret_cyc_w), 32'd4);
      end
      if (c == 8) begin
        chk("full_overflow", 32'(overflow), 32'd0);
        chk("full_retired",  retired_cnt,   32'd4);
      end
      step(1'b0, 1'b0, 1'b0);
    end
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_retired",  retired_cnt,   32'd4);
    chk("drop_hold_tag", 32'(ret_tag),  32'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].tag == 8'd4) begin
        exp_q.delete(i);
        break;
      end
    end
    ret_ready = 1'b1;
    for (int c = 9; c < 22; c++) step(1'b0, 1'b0, 1'b0);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Full FIFO, consumer pops on the same edge as a push: no drop.
    do_reset(1);
    for (int c = 0; c < 20; c++) begin
      ret_ready = (c >= 8);
      if (c == 8) begin
        chk("simul_pre_retired", retired_cnt,   32'd4);
        chk("simul_pre_overflow", 32'(overflow), 32'd0);
      end
      if (c == 9) begin
        chk("simul_overflow", 32'(overflow), 32'd0);
        chk("simul_retired",  retired_cnt,   32'd5);
      end
      step(1'b0, 1'b0, 1'b0);
    end
    chk("simul_end_overflow", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
